test_ctrl: RTL

//  Synthesizable run controller that replaces per-test hand-timed reset/finish sequencing.

---
 rtl/test_ctrl_if.sv | 28 ++
 rtl/test_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/test_ctrl_if.sv
// Core-side channel of the test run controller.
//   tohost_valid  per-hart tohost write strobe
//   tohost_data   per-hart tohost write data, hart i at [32*i +: 32]
//   retire        per-hart instruction-retired strobe
//   core_reset    active-high reset driven back to the core
// master: the core under test; slave: test_ctrl.
interface test_ctrl_if #(
  parameter int unsigned NUM_HARTS = 1
);
  logic [NUM_HARTS-1:0]    tohost_valid;
  logic [32*NUM_HARTS-1:0] tohost_data;
  logic [NUM_HARTS-1:0]    retire;
  logic                    core_reset;

  modport master (
    output tohost_valid,
    output tohost_data,
    output retire,
    input  core_reset
  );

  modport slave (
    input  tohost_valid,
    input  tohost_data,
    input  retire,
    output core_reset
  );
endinterface

// File: rtl/test_ctrl.sv
// Run controller for riscv-tests style programs. Holds the core in reset for RESET_CYCLES,
// then counts run cycles and decodes tohost writes from every hart into a sticky
// pass / fail / timeout verdict. restart re-runs the test from the reset hold.
//
// Optional feature: define TEST_CTRL_STALL_WDOG_EN to build a per-hart stall watchdog that
// fails the run (code 31'h7FFF_FFFF) when a not-yet-passed hart goes STALL_CYCLES run cycles
// without retiring. Without it, retire is ignored.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low block reset
//   restart      synchronous pulse, rerun the test from the reset hold
//   core         test_ctrl_if.slave: tohost_valid/tohost_data/retire in, core_reset out
//   done         test finished (pass, fail or timeout)
//   pass         every hart wrote tohost = 1
//   fail         a hart wrote an odd tohost value other than 1 (or stalled)
//   timeout      run-cycle budget exhausted
//   fail_hart    index of the failing hart
//   fail_code    tohost_data[31:1] of the failing write
//   cycle_count  cycles spent in RUN, saturating
module test_ctrl #(
  parameter int unsigned NUM_HARTS    = 1,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 60,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned STALL_CYCLES = 16,
  localparam int unsigned HART_W      = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  test_ctrl_if.slave        core,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [HART_W-1:0] fail_hart,
  output logic [30:0]       fail_code,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned HoldW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_CYCLES - 1);
  localparam bit TimeoutEn = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] LastCycle = CNT_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

  typedef enum logic [2:0] {StHold, StRun, StPass, StFail, StTimeout} state_e;

  state_e               state_q, state_d;
  logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_HARTS-1:0] mask_q, mask_d;
  logic [HART_W-1:0]    hart_q, hart_d;
  logic [30:0]          code_q, code_d;
  logic                 core_reset_q, done_q, pass_q, fail_q, timeout_q;

  logic [NUM_HARTS-1:0] pass_hit, fail_hit, stall_hit;

  // Per-hart tohost decode: 1 = pass, other odd values = fail, even values = proxy call.
  for (genvar i = 0; i < NUM_HARTS; i++) begin : g_decode
    logic [31:0] data;
    assign data        = core.tohost_data[32*i +: 32];
    assign pass_hit[i] = core.tohost_valid[i] && (data == 32'd1);
    assign fail_hit[i] = core.tohost_valid[i] && data[0] && (data != 32'd1);
  end

`ifdef TEST_CTRL_STALL_WDOG_EN
  localparam int unsigned StallW = $clog2(STALL_CYCLES + 1);
  localparam logic [StallW-1:0] StallLast = StallW'(STALL_CYCLES - 1);

  for (genvar i = 0; i < NUM_HARTS; i++) begin : g_stall
    logic [StallW-1:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stall_q <= '0;
      end else if (restart || (state_q == StHold) || core.retire[i]) begin
        stall_q <= '0;
      end else if ((state_q == StRun) && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end

    // Fires in the run cycle that would bring the counter to STALL_CYCLES.
    assign stall_hit[i] = (state_q == StRun) && !core.retire[i] && !mask_q[i] &&
                          (stall_q == StallLast);
  end
`else
  logic unused_retire;
  assign unused_retire = ^core.retire;
  assign stall_hit     = '0;
`endif

  logic              any_fail;
  logic [HART_W-1:0] first_hart;
  logic [30:0]       first_code;
  logic [NUM_HARTS-1:0] mask_next;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    hart_d     = hart_q;
    code_d     = code_q;
    any_fail   = 1'b0;
    first_hart = '0;
    first_code = '0;
    mask_next  = mask_q | pass_hit;

    // Walk downwards so the lowest failing hart is the one left standing.
    for (int i = int'(NUM_HARTS) - 1; i >= 0; i--) begin
      if (fail_hit[i] || stall_hit[i]) begin
        any_fail   = 1'b1;
        first_hart = HART_W'(i);
        first_code = fail_hit[i] ? core.tohost_data[32*i+1 +: 31] : 31'h7FFF_FFFF;
      end
    end

    if (restart) begin
      state_d    = StHold;
      hold_cnt_d = '0;
      cnt_d      = '0;
      mask_d     = '0;
      hart_d     = '0;
      code_d     = '0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (hold_cnt_q == HoldLast) begin
            state_d    = StRun;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        StRun: begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          if (any_fail) begin
            state_d = StFail;
            hart_d  = first_hart;
            code_d  = first_code;
          end else if (&mask_next) begin
            state_d = StPass;
            mask_d  = mask_next;
          end else begin
            mask_d = mask_next;
            if (TimeoutEn && (cnt_q == LastCycle)) begin
              state_d = StTimeout;
            end
          end
        end
        default: ; // terminal states are sticky until restart
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StHold;
      hold_cnt_q   <= '0;
      cnt_q        <= '0;
      mask_q       <= '0;
      hart_q       <= '0;
      code_q       <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      hart_q       <= hart_d;
      code_q       <= code_d;
      core_reset_q <= (state_d != StRun);
      done_q       <= (state_d == StPass) || (state_d == StFail) || (state_d == StTimeout);
      pass_q       <= (state_d == StPass);
      fail_q       <= (state_d == StFail);
      timeout_q    <= (state_d == StTimeout);
    end
  end

  assign core.core_reset = core_reset_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign fail            = fail_q;
  assign timeout         = timeout_q;
  assign fail_hart       = hart_q;
  assign fail_code       = code_q;
  assign cycle_count     = cnt_q;

endmodule
